// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store front end for a 1024x32 negedge BRAM.
// Accepts one byte-addressed request at a time, word-aligns the address,
// extends sub-word loads, performs SB/SH as read-modify-write and flags
// misaligned/illegal accesses without strobing memory. All outputs registered.

module mem_access_unit #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32   // only 32 is supported
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_wr_no,
  output logic                  mem_rd_no
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_RD  = 3'd1,
    S_ST_WR  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            off_q, off_d;          // byte offset within the word
  logic [2:0]            funct3_q, funct3_d;
  logic [15:0]           wdata_q, wdata_d;      // only the low half feeds SB/SH merges
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [WORDS-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_wr_n_q, mem_wr_n_d;
  logic                  mem_rd_n_q, mem_rd_n_d;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic                  req_bad;

  logic [7:0]            lane [4];              // little-endian byte lanes of the read word
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Upper address bits wrap and are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:WORDS+2];

  // Classify the incoming request: illegal funct3 for its direction, or misaligned.
  always_comb begin
    if (we_i) begin
      req_illegal = !(funct3_i inside {F3_B, F3_H, F3_W});
    end else begin
      req_illegal = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    req_misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i == F3_W) && (addr_i[1:0] != 2'b00));
    req_bad = req_illegal || req_misaligned;
  end

  // Split the memory word into lanes and build the SB/SH merged word lane by lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = gi;
    logic       hit;
    logic [7:0] src;
    assign lane[gi] = mem_data_i[8*gi +: 8];
    assign hit = ((funct3_q == F3_B) && (off_q == LANE)) ||
                 ((funct3_q == F3_H) && (off_q[1] == LANE[1]));
    assign src = ((funct3_q == F3_H) && LANE[0]) ? wdata_q[15:8] : wdata_q[7:0];
    assign merged[8*gi +: 8] = hit ? src : lane[gi];
  end

  // Select the addressed lane and sign/zero-extend the load result.
  always_comb begin
    ld_byte = lane[off_q];
    ld_half = off_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (funct3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_ext = {24'b0, ld_byte};
      F3_HU:   ld_ext = {16'b0, ld_half};
      default: ld_ext = mem_data_i;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      off_q      <= 2'b00;
      funct3_q   <= 3'b000;
      wdata_q    <= 16'h0000;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wr_n_q <= 1'b1;
      mem_rd_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_n_q <= mem_wr_n_d;
      mem_rd_n_q <= mem_rd_n_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (req_bad) begin
            state_d = S_ERR;
          end else if (!we_i) begin
            state_d = S_LD_RD;
          end else if (funct3_i == F3_W) begin
            state_d = S_ST_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RMW_RD: state_d = S_RMW_WR;
      S_LD_RD,
      S_ST_WR,
      S_RMW_WR,
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes default inactive so each is a single-cycle pulse.
  always_comb begin
    off_d      = off_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wr_n_d = 1'b1;
    mem_rd_n_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          off_d      = addr_i[1:0];
          funct3_d   = funct3_i;
          wdata_d    = wdata_i[15:0];
          mem_addr_d = addr_i[WORDS+1:2];
          busy_d     = 1'b1;
          if (!req_bad) begin
            if (!we_i) begin
              mem_rd_n_d = 1'b0;
            end else if (funct3_i == F3_W) begin
              mem_wr_n_d = 1'b0;
              mem_data_d = wdata_i;
            end else begin
              mem_rd_n_d = 1'b0;
            end
          end
        end
      end
      S_LD_RD: begin
        rdata_d = ld_ext;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_ST_WR: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      S_RMW_RD: begin
        mem_data_d = merged;
        mem_wr_n_d = 1'b0;
      end
      S_RMW_WR: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      S_ERR: begin
        done_d = 1'b1;
        err_d  = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_wr_no  = mem_wr_n_q;
  assign mem_rd_no  = mem_rd_n_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a negedge BRAM model.
// Stimulus pushes the expected completion; a monitor pops on every done_o.

module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        busy_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_wr_no;
  logic        mem_rd_no;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .req_i      (req_i),
    .we_i       (we_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_wr_no  (mem_wr_no),
    .mem_rd_no  (mem_rd_no)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:1023];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endfunction

  // BRAM model: read and write sampled on the falling edge.
  initial begin
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!mem_rd_no) begin
        mem_data_i = mem[mem_addr_o];
        rd_cnt++;
      end
      if (!mem_wr_no) begin
        mem[mem_addr_o] = mem_data_o;
        wr_cnt++;
      end
      if (!mem_rd_no && !mem_wr_no) both_cnt++;
    end
  end

  // Monitor: compare every completion against the oldest expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done_o=1 err_o=%0b rdata_o=%08h, expected no completion", err_o, rdata_o);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " rdata"}, rdata_o, e.rdata);
          check({e.name, " err"}, {31'b0, err_o}, {31'b0, e.err});
          check({e.name, " busy_in_done"}, {31'b0, busy_o}, 32'd0);
        end
      end else if (err_o) begin
        n_checks++;
        $display("FAIL stray_err: err_o=1 with done_o=0, expected err_o=0");
      end
    end
  end

  task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input int exp_rd, input int exp_wr,
                        input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   lat;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    e.name = name; e.rdata = exp_rdata; e.err = exp_err;
    exp_q.push_back(e);
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    check({name, " mem_addr"}, {22'b0, mem_addr_o}, {22'b0, addr[11:2]});
    check({name, " busy"}, {31'b0, busy_o}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk_i);
      #1;
      lat++;
    end while (!done_o && lat < 20);
    check({name, " latency"}, lat, exp_lat);
    check({name, " rd_strobes"}, rd_cnt, exp_rd);
    check({name, " wr_strobes"}, wr_cnt, exp_wr);
    check({name, " both_low"}, both_cnt, 0);
    $display("txn %-12s we=%0b f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d rd=%0d wr=%0d",
             name, we, f3, addr, wd, rdata_o, err_o, lat, rd_cnt, wr_cnt);
  endtask

  initial begin
    reset_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
    addr_i = '0; wdata_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[18] = 32'hD0B0A090;

    repeat (3) @(posedge clk_i);
    #1;
    check("reset busy", {31'b0, busy_o}, 32'd0);
    check("reset done", {31'b0, done_o}, 32'd0);
    check("reset err", {31'b0, err_o}, 32'd0);
    check("reset rdata", rdata_o, 32'h0);
    check("reset wr_n", {31'b0, mem_wr_no}, 32'd1);
    check("reset rd_n", {31'b0, mem_rd_no}, 32'd1);
    check("reset mem_addr", {22'b0, mem_addr_o}, 32'h0);
    check("reset mem_data", mem_data_o, 32'h0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Loads from mem[18] = D0B0A090
    do_txn("LB 48",  1'b0, 3'b000, 32'h48, 32'h0, 1, 1, 0, 32'hFFFFFF90, 1'b0);
    do_txn("LBU 49", 1'b0, 3'b100, 32'h49, 32'h0, 1, 1, 0, 32'h000000A0, 1'b0);
    do_txn("LH 4A",  1'b0, 3'b001, 32'h4A, 32'h0, 1, 1, 0, 32'hFFFFD0B0, 1'b0);
    do_txn("LHU 4A", 1'b0, 3'b101, 32'h4A, 32'h0, 1, 1, 0, 32'h0000D0B0, 1'b0);
    do_txn("LW 48",  1'b0, 3'b010, 32'h48, 32'h0, 1, 1, 0, 32'hD0B0A090, 1'b0);

    // Stores; rdata_o keeps the last load result
    do_txn("SW 50", 1'b1, 3'b010, 32'h50, 32'hCAFEF00D, 1, 0, 1, 32'hD0B0A090, 1'b0);
    check("SW mem[20]", mem[20], 32'hCAFEF00D);
    do_txn("SB 49", 1'b1, 3'b000, 32'h49, 32'h12345677, 2, 1, 1, 32'hD0B0A090, 1'b0);
    check("SB mem[18]", mem[18], 32'hD0B07790);
    mem[18] = 32'hD0B0A090;
    do_txn("SH 4A", 1'b1, 3'b001, 32'h4A, 32'h0000BEEF, 2, 1, 1, 32'hD0B0A090, 1'b0);
    check("SH mem[18]", mem[18], 32'hBEEFA090);

    // Error cases: no strobes, rdata_o unchanged
    do_txn("LH 49 mis",  1'b0, 3'b001, 32'h49, 32'h0, 1, 0, 0, 32'hD0B0A090, 1'b1);
    do_txn("SW 52 mis",  1'b1, 3'b010, 32'h52, 32'h55555555, 1, 0, 0, 32'hD0B0A090, 1'b1);
    check("SW 52 mem[20]", mem[20], 32'hCAFEF00D);
    do_txn("LD f3=011",  1'b0, 3'b011, 32'h48, 32'h0, 1, 0, 0, 32'hD0B0A090, 1'b1);
    do_txn("ST f3=100",  1'b1, 3'b100, 32'h48, 32'h99999999, 1, 0, 0, 32'hD0B0A090, 1'b1);
    check("ST f3=100 mem[18]", mem[18], 32'hBEEFA090);

    // req_i pulsed while LD_RD is in progress must be ignored
    begin
      exp_t e;
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h48; wdata_i = 32'h0;
      @(posedge clk_i);
      #1;
      e.name = "LB busyreq"; e.rdata = 32'hFFFFFF90; e.err = 1'b0;
      exp_q.push_back(e);
      done_cnt = 0;
      req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h50; wdata_i = 32'h11111111;
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      check("busyreq done_count", done_cnt, 1);
      check("busyreq mem[20]", mem[20], 32'hCAFEF00D);
      $display("txn %-12s ignored request during load, done pulses=%0d", "LB busyreq", done_cnt);
    end

    // Reset between E1 and E2 of an SB: write must not reach memory
    mem[18] = 32'hD0B0A090;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h49; wdata_i = 32'h12345677;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("SB rst wr pending", {31'b0, mem_wr_no}, 32'd0);
    reset_ni = 1'b0;
    #1;
    check("SB rst wr_n", {31'b0, mem_wr_no}, 32'd1);
    check("SB rst busy", {31'b0, busy_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("SB rst mem[18]", mem[18], 32'hD0B0A090);
    $display("txn %-12s reset mid read-modify-write, mem[18]=%08h", "SB rst", mem[18]);
    @(negedge clk_i);
    reset_ni = 1'b1;

    do_txn("LBU 49 post", 1'b0, 3'b100, 32'h49, 32'h0, 1, 1, 0, 32'h000000A0, 1'b0);

    repeat (3) @(posedge clk_i);
    #1;
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the 1024x32 negedge BRAM and drives its address, data and active-low read/write strobes.
- Accepts one byte-addressed RV32I load or store request at a time.
- Word-aligns the address, sign- or zero-extends LB/LH/LBU/LHU results, and performs SB/SH as a read-modify-write.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- WORDS, 10, log2 of memory depth in 32-bit words; mem_addr_o width.
- DATA_WIDTH, 32, memory word width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on posedge (memory samples on negedge).
- reset_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request strobe; sampled only when busy_o=0.
- we_i  in  1  1=store, 0=load.
- funct3_i  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  byte address; bits [31:WORDS+2] ignored (wrap).
- wdata_i  in  32  store data; low byte/half used for SB/SH.
- rdata_o  out  32  extended load result; holds until the next load completes.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse coincident with done_o on misaligned/illegal access.
- busy_o  out  1  request in flight.
- mem_addr_o  out  WORDS  word address = addr_i[WORDS+1:2].
- mem_data_o  out  32  write data to memory.
- mem_data_i  in  32  memory read data.
- mem_wr_no  out  1  memory write enable, active low.
- mem_rd_no  out  1  memory read enable, active low.

Behaviour:
- All outputs are registered.
- Reset (async, immediate) drives:
  - state to IDLE
  - mem_wr_no=1, mem_rd_no=1
  - busy_o=0, done_o=0, err_o=0
  - rdata_o=0, mem_addr_o=0, mem_data_o=0
- Reset mid-operation abandons the access; a write strobe already sampled at a prior negedge is not undone.
- FSM states: IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR, ERR.
- In IDLE with req_i=1, edge E0 latches addr, funct3, we and wdata and sets busy_o=1. Next state:
  - ERR if misaligned or illegal:
    - H/HU with addr[0]=1
    - W with addr[1:0]!=0
    - load funct3 011/110/111
    - store funct3 other than 000/001/010
  - else LD_RD for any load, with mem_rd_no=0.
  - else ST_WR for SW, with mem_wr_no=0 and mem_data_o=wdata.
  - else RMW_RD for SB/SH, with mem_rd_no=0.
- LD_RD, at E1:
  - Capture mem_data_i and select the lane; byte k = word[8k+7:8k] (little-endian).
  - Extend: sign for B/H, zero for BU/HU; W passes through.
  - Write the result to rdata_o; mem_rd_no=1, done_o=1, busy_o=0; go to IDLE.
  - Load latency: done_o high in the cycle after E1.
- ST_WR: the memory writes at the intervening negedge. At E1: mem_wr_no=1, done_o=1, busy_o=0; go to IDLE.
- RMW_RD, at E1:
  - Merge the wdata byte/half into the captured word at the addressed lane.
  - mem_data_o=merged, mem_rd_no=1, mem_wr_no=0; go to RMW_WR.
- RMW_WR, at E2: mem_wr_no=1, done_o=1, busy_o=0; go to IDLE. Sub-word store latency is 2.
- ERR:
  - No memory strobe is ever asserted.
  - At E1: done_o=1, err_o=1, busy_o=0; rdata_o and memory unchanged.
- done_o/err_o clear on the following edge unless a new completion occurs.
- A new req_i may be accepted on the edge right after completion (busy_o=0 in the done_o cycle); back-to-back throughput is then 1 request per 2 cycles for loads and SW.
- req_i while busy_o=1 is ignored (not queued).
- mem_rd_no and mem_wr_no are never low simultaneously.
- mem_addr_o is stable for the whole access.

Test Plan:
- Preload mem[18]=0xD0B0A090.
  - LB 0x48 -> rdata_o=0xFFFFFF90.
  - LBU 0x49 -> 0x000000A0.
  - LH 0x4A -> 0xFFFFD0B0.
  - LHU 0x4A -> 0x0000D0B0.
  - Each: done_o one cycle after E1, exactly one mem_rd_no low cycle, mem_addr_o=0x012.
- SW 0x50 wdata 0xCAFEF00D -> one mem_wr_no low cycle, no read; mem[20]=0xCAFEF00D; done_o after E1.
- SB 0x49 wdata 0x12345677 -> read then write, mem[18]=0xD0B07790, done after E2.
- SH 0x4A wdata 0x0000BEEF -> mem[18]=0xBEEFA090.
- Error cases, each -> done_o=err_o=1 at E1, mem strobes never low, rdata_o unchanged:
  - LH 0x49
  - SW 0x52
  - load funct3=011
- Edge cases:
  - Pull reset_ni low between E1 and E2 of an SB -> mem_wr_no goes high immediately, mem[18] unchanged, busy_o=0.
  - req_i pulsed during LD_RD -> ignored, only one done_o.
